// File: rtl/systolic_weight_loader_if.sv
// Weight-loader bus: control from the sequencer, SRAM read port and array-side
// weight outputs bundled together.
interface systolic_weight_loader_if #(
  parameter int COLS   = 8,
  parameter int ADDR_W = 10
);
  logic                   start;
  logic [ADDR_W-1:0]      base_addr;
  logic                   hold;
  logic                   wmem_rd_en;
  logic [ADDR_W-1:0]      wmem_addr;
  logic [COLS-1:0][7:0]   wmem_rdata;
  logic [COLS-1:0][7:0]   weight_out;
  logic                   w_en;
  logic                   busy;
  logic                   done;

  modport master (
    output start, base_addr, hold, wmem_rdata,
    input  wmem_rd_en, wmem_addr, weight_out, w_en, busy, done
  );

  modport slave (
    input  start, base_addr, hold, wmem_rdata,
    output wmem_rd_en, wmem_addr, weight_out, w_en, busy, done
  );
endinterface

// File: rtl/systolic_weight_loader.sv
// Preloads a ROWS x COLS weight-stationary array: reads SRAM rows bottom-first
// and shifts them down the columns, gating the array's load phase via w_en.
module systolic_weight_loader #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ADDR_W = 10
) (
  input  logic                    CLK,
  input  logic                    RESET,
  systolic_weight_loader_if.slave bus
);
  localparam int CNT_W = $clog2(ROWS + 1);
  localparam logic [CNT_W-1:0] ROWS_C = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    sh_cnt_q, sh_cnt_d;
  logic                valid_q, valid_d;
  logic                fire, rd_en, wen;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      base_q   <= '0;
      rd_cnt_q <= '0;
      sh_cnt_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      rd_cnt_q <= rd_cnt_d;
      sh_cnt_q <= sh_cnt_d;
      valid_q  <= valid_d;
    end
  end

  // valid_q marks that SRAM output holds a row not yet shifted in; hold freezes it
  // because the SRAM keeps its data while no read is issued.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    rd_cnt_d = rd_cnt_q;
    sh_cnt_d = sh_cnt_q;
    valid_d  = valid_q;
    fire     = (state_q == LOAD) && !bus.hold;
    rd_en    = fire && (rd_cnt_q < ROWS_C);
    wen      = fire && valid_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d  = LOAD;
        base_d   = bus.base_addr;
        rd_cnt_d = '0;
        sh_cnt_d = '0;
        valid_d  = 1'b0;
      end
      LOAD: if (fire) begin
        valid_d = rd_en;
        if (rd_en) rd_cnt_d = rd_cnt_q + ONE_C;
        if (wen) begin
          sh_cnt_d = sh_cnt_q + ONE_C;
          if (sh_cnt_q == LAST_C) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bottom row first: read k targets base + ROWS-1-k, wrapping modulo 2^ADDR_W.
  assign bus.wmem_rd_en = rd_en;
  assign bus.wmem_addr  = rd_en ? (base_q + ADDR_W'(ROWS - 1) - ADDR_W'(rd_cnt_q)) : '0;
  assign bus.w_en       = wen;
  assign bus.busy       = (state_q == LOAD);
  assign bus.done       = (state_q == DONE);

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    assign bus.weight_out[c] = bus.wmem_rdata[c];
  end
endmodule

// File: tb/tb_systolic_weight_loader.sv
// Randomized bench for systolic_weight_loader: ROWS=4 and ROWS=1 instances checked
// cycle by cycle against a progress-count model plus a PE-column shift model.
module tb_systolic_weight_loader;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  systolic_weight_loader_if #(.COLS(2), .ADDR_W(10)) bus4();
  systolic_weight_loader_if #(.COLS(2), .ADDR_W(10)) bus1();

  systolic_weight_loader #(.ROWS(4), .COLS(2), .ADDR_W(10)) u_dut4 (
    .CLK(CLK), .RESET(RESET), .bus(bus4)
  );
  systolic_weight_loader #(.ROWS(1), .COLS(2), .ADDR_W(10)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .bus(bus1)
  );

  logic       sel;
  logic       start, hold;
  logic [9:0] base;

  assign bus4.start     = start & ~sel;
  assign bus1.start     = start & sel;
  assign bus4.hold      = hold;
  assign bus1.hold      = hold;
  assign bus4.base_addr = base;
  assign bus1.base_addr = base;

  // SRAM: 1-cycle latency, output retained while no read.
  logic [15:0] mem [0:1023];
  always @(posedge CLK) if (bus4.wmem_rd_en) bus4.wmem_rdata <= mem[bus4.wmem_addr];
  always @(posedge CLK) if (bus1.wmem_rd_en) bus1.wmem_rdata <= mem[bus1.wmem_addr];

  logic        o_rd, o_wen, o_busy, o_done;
  logic [9:0]  o_addr;
  logic [15:0] o_wout;
  assign o_rd   = sel ? bus1.wmem_rd_en : bus4.wmem_rd_en;
  assign o_wen  = sel ? bus1.w_en       : bus4.w_en;
  assign o_busy = sel ? bus1.busy       : bus4.busy;
  assign o_done = sel ? bus1.done       : bus4.done;
  assign o_addr = sel ? bus1.wmem_addr  : bus4.wmem_addr;
  assign o_wout = sel ? bus1.weight_out : bus4.weight_out;

  int nchk = 0;
  int nerr = 0;
  logic [15:0] pe [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One load: cycle 0 is the IDLE cycle carrying start; cycle n follows edge En.
  // Model: the load advances one step per unheld LOAD cycle; step j reads row
  // R-1-j (j<R) and shifts the row read at step j-1 (j>=1); done follows step R.
  task automatic run_load(input logic s, input logic [9:0] b, input int hprob,
                          input logic [31:0] hmask, input logic [31:0] smask,
                          input int sprob, output int done_n);
    int R, j, nrd, nwen, ea;
    logic e_busy, e_rd, e_wen, e_done, hm, sm;
    R = s ? 1 : 4;
    j = 0; nrd = 0; nwen = 0; done_n = -1;
    for (int r = 0; r < 8; r++) pe[r] = '0;
    @(posedge CLK); #1;
    sel = s; base = b; start = 1'b1; hold = 1'($urandom_range(0, 1));
    @(negedge CLK);
    chk("idle_busy", o_busy, 0);
    chk("idle_rd", o_rd, 0);
    for (int n = 1; n <= 200; n++) begin
      @(posedge CLK); #1;
      hm = (n < 32) ? hmask[n] : 1'b0;
      sm = (n < 32) ? smask[n] : 1'b0;
      start = sm | (int'($urandom_range(0, 99)) < sprob);
      hold  = hm | (int'($urandom_range(0, 99)) < hprob);
      @(negedge CLK);
      e_busy = (j <= R);
      e_rd   = e_busy && !hold && (j < R);
      e_wen  = e_busy && !hold && (j >= 1);
      e_done = (j == R + 1);
      chk("busy", o_busy, e_busy);
      chk("rd_en", o_rd, e_rd);
      chk("w_en", o_wen, e_wen);
      chk("done", o_done, e_done);
      if (e_rd) begin
        ea = (int'(b) + R - 1 - j) % 1024;
        chk("addr", o_addr, ea);
      end else chk("addr_idle", o_addr, 0);
      if (e_busy && j >= 1) begin
        ea = (int'(b) + R - j) % 1024;
        chk("wout", o_wout, mem[ea]);
      end
      if (o_rd) nrd++;
      if (o_wen) begin
        nwen++;
        for (int r = 7; r > 0; r--) pe[r] = pe[r-1];
        pe[0] = o_wout;
      end
      if (e_done) begin
        done_n = n;
        break;
      end
      if (e_busy && !hold) j++;
    end
    if (done_n < 0) chk("timeout", 1, 0);
    chk("n_reads", nrd, R);
    chk("n_shifts", nwen, R);
    for (int r = 0; r < R; r++) chk("pe_final", pe[r], mem[(int'(b) + r) % 1024]);
    @(posedge CLK); #1;
    start = 1'b0; hold = 1'b0;
    @(negedge CLK);
    chk("post_busy", o_busy, 0);
    chk("post_done", o_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    logic s;
    logic [9:0] b;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int r = 0; r < 4; r++) mem[r] = {8'(-(r + 1)), 8'(r + 1)};
    RESET = 1'b1; start = 1'b0; hold = 1'b0; sel = 1'b0; base = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy4", bus4.busy, 0);
    chk("rst_done4", bus4.done, 0);
    chk("rst_wen4", bus4.w_en, 0);
    chk("rst_rd4", bus4.wmem_rd_en, 0);
    chk("rst_addr4", bus4.wmem_addr, 0);
    chk("rst_busy1", bus1.busy, 0);
    chk("rst_wen1", bus1.w_en, 0);
    chk("rst_addr1", bus1.wmem_addr, 0);
    @(posedge CLK); #1 RESET = 1'b0;

    run_load(1'b0, 10'd0, 0, 32'h0, 32'h0, 0, dn);
    chk("done_cyc_plain", dn, 6);
    run_load(1'b0, 10'd0, 0, 32'h18, 32'h0, 0, dn);
    chk("done_cyc_hold", dn, 8);
    run_load(1'b0, 10'd0, 0, 32'h0, 32'h44, 0, dn);
    chk("done_cyc_restart", dn, 6);

    // Reset during cycle 3 of a load aborts it on the next edge.
    @(posedge CLK); #1 sel = 1'b0; base = 10'd0; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    chk("abort_busy", bus4.busy, 0);
    chk("abort_wen", bus4.w_en, 0);
    chk("abort_rd", bus4.wmem_rd_en, 0);
    chk("abort_done", bus4.done, 0);
    run_load(1'b0, 10'd0, 0, 32'h0, 32'h0, 0, dn);
    chk("done_cyc_after_abort", dn, 6);

    run_load(1'b0, 10'd1022, 0, 32'h0, 32'h0, 0, dn);
    chk("done_cyc_wrap", dn, 6);
    run_load(1'b1, 10'd5, 0, 32'h0, 32'h0, 0, dn);
    chk("done_cyc_rows1", dn, 3);

    repeat (24) begin
      s = 1'($urandom_range(0, 1));
      b = 10'($urandom);
      run_load(s, b, 30, 32'h0, 32'h0, 20, dn);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/systolic_weight_loader.md
Name: systolic_weight_loader

Overview:
- Upstream stage that preloads one 8-bit weight per PE into a ROWS x COLS weight-stationary systolic array.
- Reads one array row (COLS packed int8 weights) per cycle from a synchronous weight SRAM and drives the top-row weight inputs and the shared weight-load enable.
- Weights shift down each column one row per load cycle, so rows are pushed bottom row first and top row last.
- While w_en is high the array does not accumulate, so the loader also acts as the array's load/compute phase gate.

Parameters:
- ROWS, 8, number of PE rows (shift depth); legal range ≥1.
- COLS, 8, number of PE columns; one int8 lane per column.
- ADDR_W, 10, weight SRAM address width.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  SRAM address of array row 0; row r is stored at base_addr+r; captured on start.
- hold  in  1  stall; freezes the loader and suppresses reads and shifts.
- wmem_rd_en  out  1  SRAM read enable (combinational).
- wmem_addr  out  ADDR_W  SRAM read address (combinational).
- wmem_rdata  in  COLS*8  SRAM data, 1-cycle latency; the SRAM holds rdata while rd_en=0.
- weight_out  out  COLS*8  to the top-row weight inputs; lane c = bits [8c+7:8c], signed; equals wmem_rdata.
- w_en  out  1  shared PE weight-load enable (combinational).
- busy  out  1  high from the cycle after start acceptance through the last shift cycle.
- done  out  1  one-cycle pulse after the final shift.

Behaviour:
- States: IDLE, LOAD, DONE.
  - IDLE→LOAD when start=1: base_addr is latched and rd_cnt=sh_cnt=valid_q=0.
  - LOAD→DONE on the edge that completes shift ROWS.
  - DONE→IDLE unconditionally after one cycle.
- Reset (synchronous) sets: state=IDLE, counters=0, valid_q=0, busy=0, done=0, w_en=0, wmem_rd_en=0, wmem_addr=0.
- fire = (state==LOAD) & ~hold.
- Reads:
  - wmem_rd_en = fire & (rd_cnt<ROWS).
  - wmem_addr = base_q + (ROWS-1-rd_cnt), computed modulo 2^ADDR_W; wrap is permitted and not flagged.
  - rd_cnt increments on each issued read.
- valid_q tracks the data pipeline:
  - When fire=1: valid_q <= wmem_rd_en.
  - When hold=1: valid_q is retained.
- Shifts:
  - w_en = fire & valid_q.
  - sh_cnt increments on each w_en cycle.
  - The final shift is the one where sh_cnt==ROWS-1.
- Order: shift k (k=0..ROWS-1) carries SRAM row ROWS-1-k. After ROWS shifts, PE row r holds SRAM row r.
- Timing, start accepted at edge E0, no hold (cycle n follows edge En):
  - rd_en high in cycles 1..ROWS.
  - w_en high in cycles 2..ROWS+1.
  - busy high in cycles 1..ROWS+1.
  - done high in cycle ROWS+2.
  - Total latency is ROWS+2 cycles.
- hold:
  - Any hold cycle inserts exactly one cycle of delay.
  - While held: no read, no shift, counters frozen, weight_out stable because the SRAM retains its output.
  - hold in IDLE or DONE has no effect.
- start while busy or in DONE is ignored; the load in progress is not restarted.
- ROWS=1: a single read and a single shift; done in cycle 3.
- Reset mid-load aborts immediately; w_en=0 from the next cycle. PE weights are left partially shifted, and a fresh start is required before any compute.
- The array's EN must be high whenever w_en=1. This is the system controller's duty; the loader does not check it.

Test Plan:
- ROWS=4, COLS=2, SRAM rows 0..3 = {1,-1},{2,-2},{3,-3},{4,-4}, base=0, start at cycle 0 → addr 3,2,1,0 in cycles 1-4; w_en in cycles 2-5; weight_out {4,-4},{3,-3},{2,-2},{1,-1}; done in cycle 6; a PE-column model ends with row r = {r+1,-(r+1)}.
- Same setup with hold=1 in cycles 3-4 → w_en cycles 2,5,6,7; weight_out held at {3,-3} during hold; done in cycle 8; final weights identical.
- start pulsed again in cycles 2 and 6 of a load → ignored; exactly 4 reads and 4 shifts; single done pulse.
- RESET asserted in cycle 3 of a load → cycle 4: busy=0, w_en=0, rd_en=0, state IDLE; a new start performs a full ROWS-cycle load.
- base_addr=2^ADDR_W-2, ROWS=4 → addresses 1,0,1023,1022 (ADDR_W=10), wrapping modulo 2^ADDR_W.
- ROWS=1, base=5 → rd_en cycle 1 addr 5; w_en cycle 2; done cycle 3.
